// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game sequencer.
//   state_e      : 2-bit FSM encoding (NEWGAME, PLAY, NEWBALL, OVER)
//   bcd_t        : one 4-bit BCD digit
//   *_DEF        : default balls per game and inter-round delay in frames
package pong_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned BALLS_W = 2;
    localparam int unsigned TIMER_W = 8;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SCORE_W = 2 * DIGIT_W;

    localparam int unsigned BALLS_INIT_DEF   = 3;
    localparam int unsigned TIMER_FRAMES_DEF = 120;

    typedef enum logic [STATE_W-1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_e;

    typedef logic [DIGIT_W-1:0] bcd_t;

endpackage

// File: rtl/pong_bcd_cnt2.sv
// Two-digit BCD up-counter, 00..99 with wrap to 00. clr has priority over inc.
//   clk, reset : clock, asynchronous active-high reset (count -> 00)
//   clr_i      : synchronous clear
//   inc_i      : add one this clock
//   count_o    : {tens, units} BCD, registered
module pong_bcd_cnt2
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [SCORE_W-1:0] count_o
);

    bcd_t units_q, units_d;
    bcd_t tens_q,  tens_d;

    // Next-count: units roll 9->0 and carry into tens; tens roll 9->0 too.
    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (clr_i) begin
            units_d = '0;
            tens_d  = '0;
        end else if (inc_i) begin
            if (units_q == DIGIT_W'(9)) begin
                units_d = '0;
                tens_d  = (tens_q == DIGIT_W'(9)) ? '0 : tens_q + DIGIT_W'(1);
            end else begin
                units_d = units_q + DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            units_q <= '0;
            tens_q  <= '0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

    assign count_o = {tens_q, units_q};

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new game, play, ball re-serve and game over.
// Optional feature macro: PONG_HISCORE_EN (keeps best score; otherwise hiscore = 00).
//   clk, reset : clock, asynchronous active-high reset
//   frame_tick : one-clock pulse per video frame
//   btn        : player buttons (level, synchronised); any rising press counts
//   hit        : ball/paddle contact level; counted once per rising edge in PLAY
//   miss       : ball lost level; acted on only in PLAY
//   gra_still  : 1 = freeze/recentre ball (every state except PLAY)
//   state      : current FSM state
//   balls      : balls remaining including the one in play
//   score      : BCD {tens, units}
//   hiscore    : BCD best score
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALLS_INIT   = BALLS_INIT_DEF,
    parameter int unsigned TIMER_FRAMES = TIMER_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [3:0]         btn,
    input  logic               hit,
    input  logic               miss,
    output logic               gra_still,
    output logic [STATE_W-1:0] state,
    output logic [BALLS_W-1:0] balls,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hiscore
);

    localparam logic [BALLS_W-1:0] BALLS_LOAD = BALLS_W'(BALLS_INIT);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMER_FRAMES);

    state_e             state_q, state_d;
    logic               gra_still_q, gra_still_d;
    logic [BALLS_W-1:0] balls_q, balls_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               hit_q;
    logic               btn_any_q;

    logic               hit_rise_c;
    logic               btn_rise_c;
    logic               score_clr_c;
    logic               score_inc_c;
    logic [SCORE_W-1:0] score_c;

    assign hit_rise_c = hit & ~hit_q;
    assign btn_rise_c = (|btn) & ~btn_any_q;

    // Next-state and datapath controls.
    always_comb begin
        state_d     = state_q;
        balls_d     = balls_q;
        timer_d     = timer_q;
        score_clr_c = 1'b0;
        score_inc_c = 1'b0;

        unique case (state_q)
            ST_NEWGAME: begin
                balls_d     = BALLS_LOAD;
                score_clr_c = 1'b1;
                if (btn_rise_c) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A miss outranks a simultaneous hit: the point is not scored.
                if (miss) begin
                    timer_d = TIMER_LOAD;
                    if (balls_q <= BALLS_W'(1)) begin
                        balls_d = '0;
                        state_d = ST_OVER;
                    end else begin
                        balls_d = balls_q - BALLS_W'(1);
                        state_d = ST_NEWBALL;
                    end
                end else if (hit_rise_c) begin
                    score_inc_c = 1'b1;
                end
            end
            ST_NEWBALL: begin
                if (frame_tick && (timer_q != '0)) begin
                    timer_d = timer_q - TIMER_W'(1);
                end
                // Only a press seen after the delay has fully expired re-serves.
                if (btn_rise_c && (timer_q == '0)) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                // Load the new-game values on the way out so outputs match the state.
                if (timer_q == '0) begin
                    state_d     = ST_NEWGAME;
                    balls_d     = BALLS_LOAD;
                    score_clr_c = 1'b1;
                end else if (frame_tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_NEWGAME;
            end
        endcase

        gra_still_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_NEWGAME;
            gra_still_q <= 1'b1;
            balls_q     <= BALLS_LOAD;
            timer_q     <= '0;
            hit_q       <= 1'b0;
            btn_any_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gra_still_q <= gra_still_d;
            balls_q     <= balls_d;
            timer_q     <= timer_d;
            hit_q       <= hit;
            btn_any_q   <= |btn;
        end
    end

    pong_bcd_cnt2 u_score (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (score_clr_c),
        .inc_i   (score_inc_c),
        .count_o (score_c)
    );

`ifdef PONG_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;

    // Capture on entry to OVER; BCD compares correctly as plain binary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiscore_q <= '0;
        end else if ((state_q == ST_PLAY) && (state_d == ST_OVER) && (score_c > hiscore_q)) begin
            hiscore_q <= score_c;
        end
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = SCORE_W'(0);
`endif

    assign gra_still = gra_still_q;
    assign state     = state_q;
    assign balls     = balls_q;
    assign score     = score_c;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl (default parameters: 3 balls, 120-frame delay).
// Stimulus pushes hand-computed expected outputs; a negedge monitor pops and compares.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [1:0] state;
    logic [1:0] balls;
    logic [7:0] score;
    logic [7:0] hiscore;

    localparam logic [1:0] S_NG = 2'd0, S_PL = 2'd1, S_NB = 2'd2, S_OV = 2'd3;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn        (btn),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .state      (state),
        .balls      (balls),
        .score      (score),
        .hiscore    (hiscore)
    );

    typedef struct {
        int         due;
        string      tag;
        logic [1:0] st;
        logic       still;
        logic [1:0] balls;
        logic [7:0] score;
        logic [7:0] hi;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_hi = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input string field, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h (cycle %0d)", tag, field, act, exp, cyc);
        end
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            chk(e.tag, "state",     8'(state),     8'(e.st));
            chk(e.tag, "gra_still", 8'(gra_still), 8'(e.still));
            chk(e.tag, "balls",     8'(balls),     8'(e.balls));
            chk(e.tag, "score",     score,         e.score);
            chk(e.tag, "hiscore",   hiscore,       e.hi);
        end
    end

    task automatic expect_out(input string tag, input logic [1:0] st, input logic [1:0] b, input logic [7:0] sc);
        exp_t e;
        e.due   = cyc;
        e.tag   = tag;
        e.st    = st;
        e.still = (st != S_PL);
        e.balls = b;
        e.score = sc;
        e.hi    = exp_hi;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
    endtask

    task automatic set_hi_on_over(input logic [7:0] v);
`ifdef PONG_HISCORE_EN
        exp_hi = v;
`else
        exp_hi = 8'h00;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, both during and after reset.
        repeat (3) @(posedge clk);
        #1;
        expect_out("rst_active", S_NG, 2'd3, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        expect_out("rst_idle", S_NG, 2'd3, 8'h00);

        // Start: one-clock press moves to PLAY after the next edge.
        btn = 4'b0001;
        tick();
        expect_out("start", S_PL, 2'd3, 8'h00);
        btn = 4'b0000;
        tick();

        // Held hit counts once; then three single-clock pulses.
        hit = 1'b1;
        tick();
        expect_out("hit_first", S_PL, 2'd3, 8'h01);
        repeat (49) tick();
        expect_out("hit_held", S_PL, 2'd3, 8'h01);
        hit = 1'b0;
        tick();
        repeat (3) pulse_hit();
        expect_out("pulses", S_PL, 2'd3, 8'h04);

        // BCD carry up to 99, wrap to 00.
        repeat (95) pulse_hit();
        expect_out("s99", S_PL, 2'd3, 8'h99);
        pulse_hit();
        expect_out("wrap", S_PL, 2'd3, 8'h00);
        pulse_hit();
        expect_out("s01", S_PL, 2'd3, 8'h01);

        // Hit and miss together: miss wins.
        hit  = 1'b1;
        miss = 1'b1;
        tick();
        expect_out("hit_miss", S_NB, 2'd2, 8'h01);
        hit = 1'b0;
        repeat (5) tick();
        expect_out("miss_held", S_NB, 2'd2, 8'h01);
        miss = 1'b0;
        tick();

        // Re-serve only once the delay has fully expired.
        frame();
        frame();
        btn = 4'b0010;
        tick();
        expect_out("early_btn", S_NB, 2'd2, 8'h01);
        btn = 4'b0000;
        tick();
        repeat (117) frame();
        btn = 4'b0100;
        tick();
        expect_out("btn_t1", S_NB, 2'd2, 8'h01);
        btn = 4'b0000;
        tick();
        frame();
        btn = 4'b1000;
        tick();
        expect_out("serve", S_PL, 2'd2, 8'h01);
        btn = 4'b0000;
        tick();

        // Game one ends at score 12.
        repeat (11) pulse_hit();
        expect_out("s12", S_PL, 2'd2, 8'h12);
        miss = 1'b1;
        tick();
        expect_out("miss2", S_NB, 2'd1, 8'h12);
        miss = 1'b0;
        tick();
        repeat (120) frame();
        btn = 4'b0001;
        tick();
        expect_out("serve2", S_PL, 2'd1, 8'h12);
        btn = 4'b0000;
        tick();
        miss = 1'b1;
        tick();
        set_hi_on_over(8'h12);
        expect_out("over", S_OV, 2'd0, 8'h12);
        miss = 1'b0;
        btn  = 4'b0001;
        repeat (119) frame();
        expect_out("over_t1", S_OV, 2'd0, 8'h12);
        frame();
        expect_out("newgame", S_NG, 2'd3, 8'h00);
        repeat (10) tick();
        expect_out("held_btn", S_NG, 2'd3, 8'h00);
        btn = 4'b0000;
        tick();
        btn = 4'b0001;
        tick();
        expect_out("fresh", S_PL, 2'd3, 8'h00);
        btn = 4'b0000;
        tick();

        // Game two ends at 07: best score stays 12.
        repeat (7) pulse_hit();
        expect_out("s07", S_PL, 2'd3, 8'h07);
        for (int b = 3; b >= 2; b--) begin
            miss = 1'b1;
            tick();
            expect_out("g2_miss", S_NB, 2'(b - 1), 8'h07);
            miss = 1'b0;
            tick();
            repeat (120) frame();
            btn = 4'b0001;
            tick();
            expect_out("g2_serve", S_PL, 2'(b - 1), 8'h07);
            btn = 4'b0000;
            tick();
        end
        miss = 1'b1;
        tick();
        expect_out("over2", S_OV, 2'd0, 8'h07);
        miss = 1'b0;
        repeat (120) frame();
        expect_out("newgame2", S_NG, 2'd3, 8'h00);
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        tick();
        pulse_hit();
        expect_out("pre_rst", S_PL, 3'd3 == 3'd3 ? 2'd3 : 2'd3, 8'h01);

        // Asynchronous reset mid-PLAY, checked before any further clock edge.
        @(posedge clk);
        #3;
        reset  = 1'b1;
        exp_hi = 8'h00;
        expect_out("async_rst", S_NG, 2'd3, 8'h00);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        expect_out("post_rst", S_NG, 2'd3, 8'h00);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
